// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus fabric: target encoding, default map, address decode.
package bus_pkg;
   typedef enum logic [1:0] {TGT_ROM, TGT_RAM, TGT_RGB} tgt_e;

   localparam int unsigned DEF_RAM_BASE = 32'h0000_8000;
   localparam int unsigned DEF_RGB_ADDR = 32'h0000_FFFF;

   // The RGB register sits inside the RAM window, so it is matched first.
   function automatic tgt_e decode_tgt(input logic [31:0] addr,
                                       input logic [31:0] ram_base,
                                       input logic [31:0] rgb_addr);
      if (addr == rgb_addr) return TGT_RGB;
      if (addr >= ram_base) return TGT_RAM;
      return TGT_ROM;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after i_ptr wins, wrapping; purely combinational.
// Zero latency; no backpressure of its own, the caller decides when a grant is consumed.
module rr_arbiter #(
   parameter  int NUM_MASTERS = 2,
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic [NUM_MASTERS-1:0] i_req,
   input  logic [IDX_W-1:0]       i_ptr,
   output logic [NUM_MASTERS-1:0] o_gnt,
   output logic [IDX_W-1:0]       o_idx,
   output logic                   o_any
);
   logic [IDX_W-1:0] w_cand;

   // Scan from the farthest candidate back towards i_ptr so the nearest one is written last.
   always_comb begin
      w_cand = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         w_cand = IDX_W'((int'(i_ptr) + k) % NUM_MASTERS);
         if (i_req[w_cand]) begin
            o_idx = w_cand;
            o_any = 1'b1;
         end
      end
      o_gnt = '0;
      if (o_any) o_gnt[o_idx] = 1'b1;
   end
endmodule

// File: rtl/mem_bus_fabric.sv
// Round-robin fabric from NUM_MASTERS masters to ROM, RAM and an RGB register; issue in the grant cycle,
// completion one cycle later; masters hold m_req until granted. BUS_LOCK_EN enables m_lock bus locking.
module mem_bus_fabric
   import bus_pkg::*;
#(
   parameter int          NUM_MASTERS = 2,
   parameter int          ADDR_W      = 16,
   parameter int          DATA_W      = 16,
   parameter int unsigned RAM_BASE    = DEF_RAM_BASE,
   parameter int unsigned RGB_ADDR    = DEF_RGB_ADDR,
   parameter int          RGB_W       = 13
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [NUM_MASTERS-1:0]        m_we,
   input  logic [NUM_MASTERS-1:0]        m_lock,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]        m_gnt,
   output logic [NUM_MASTERS-1:0]        m_rvalid,
   output logic [NUM_MASTERS-1:0]        m_err,
   output logic [DATA_W-1:0]             m_rdata,
   output logic [ADDR_W-1:0]             rom_addr,
   input  logic [DATA_W-1:0]             rom_rdata,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic                          ram_we,
   output logic [DATA_W-1:0]             ram_wdata,
   input  logic [DATA_W-1:0]             ram_rdata,
   output logic [RGB_W-1:0]              rgb
);
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [IDX_W-1:0]       r_rr_ptr, r_pend_idx;
   logic                   r_pend_vld, r_pend_we;
   tgt_e                   r_pend_tgt;
   logic [DATA_W-1:0]      r_pend_rgb;
   logic [RGB_W-1:0]       r_rgb;
   logic [ADDR_W-1:0]      r_last_addr;
   logic [DATA_W-1:0]      r_last_wdata;

   logic [NUM_MASTERS-1:0] w_req_eff, w_gnt;
   logic [IDX_W-1:0]       w_idx;
   logic                   w_any, w_issue, w_hold, w_we;
   logic [ADDR_W-1:0]      w_addr;
   logic [DATA_W-1:0]      w_wdata;
   tgt_e                   w_tgt;

`ifdef BUS_LOCK_EN
   logic             r_lock_vld;
   logic [IDX_W-1:0] r_lock_idx;
   logic             w_locked;

   // The lock holder stays the only candidate while it keeps both lock and request up.
   assign w_locked = r_lock_vld && m_req[r_lock_idx] && m_lock[r_lock_idx];
   assign w_hold   = w_issue && m_lock[w_idx];

   always_comb begin
      w_req_eff = m_req;
      if (w_locked) begin
         w_req_eff             = '0;
         w_req_eff[r_lock_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock_vld <= 1'b0;
         r_lock_idx <= '0;
      end else begin
         r_lock_vld <= w_hold;
         if (w_issue) r_lock_idx <= w_idx;
      end
   end
`else
   logic w_unused_lock;
   assign w_unused_lock = ^m_lock;
   assign w_req_eff     = m_req;
   assign w_hold        = 1'b0;
`endif

   rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
      .i_req (w_req_eff),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign m_gnt   = w_gnt;
   assign w_issue = w_any && !reset;
   assign w_we    = m_we[w_idx];
   assign w_addr  = m_addr[w_idx*ADDR_W +: ADDR_W];
   assign w_wdata = m_wdata[w_idx*DATA_W +: DATA_W];
   assign w_tgt   = decode_tgt(32'(w_addr), 32'(RAM_BASE), 32'(RGB_ADDR));

   assign rom_addr  = w_issue ? w_addr  : r_last_addr;
   assign ram_addr  = w_issue ? w_addr  : r_last_addr;
   assign ram_wdata = w_issue ? w_wdata : r_last_wdata;
   assign ram_we    = w_issue && w_we && (w_tgt == TGT_RAM);
   assign rgb       = r_rgb;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr     <= '0;
         r_pend_vld   <= 1'b0;
         r_pend_idx   <= '0;
         r_pend_we    <= 1'b0;
         r_pend_tgt   <= TGT_ROM;
         r_pend_rgb   <= '0;
         r_rgb        <= '0;
         r_last_addr  <= '0;
         r_last_wdata <= '0;
      end else begin
         r_pend_vld <= w_issue;
         if (w_issue) begin
            r_pend_idx   <= w_idx;
            r_pend_we    <= w_we;
            r_pend_tgt   <= w_tgt;
            r_pend_rgb   <= DATA_W'(r_rgb);
            r_last_addr  <= w_addr;
            r_last_wdata <= w_wdata;
            if (!w_hold) r_rr_ptr <= IDX_W'((int'(w_idx) + 1) % NUM_MASTERS);
            if (w_we && w_tgt == TGT_RGB) r_rgb <= w_wdata[RGB_W-1:0];
         end
      end
   end

   // Completion is squashed while reset is high so an in-flight read never surfaces.
   always_comb begin
      m_rvalid = '0;
      m_err    = '0;
      m_rdata  = '0;
      if (r_pend_vld && !reset) begin
         m_rvalid[r_pend_idx] = 1'b1;
         case (r_pend_tgt)
            TGT_ROM: begin
               if (r_pend_we) m_err[r_pend_idx] = 1'b1;
               else           m_rdata = rom_rdata;
            end
            TGT_RAM: if (!r_pend_we) m_rdata = ram_rdata;
            default: if (!r_pend_we) m_rdata = r_pend_rgb;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric with behavioural ROM/RAM models (two masters, default map).
module tb_mem_bus_fabric;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  m_req, m_we, m_lock, m_gnt, m_rvalid, m_err;
   logic [31:0] m_addr, m_wdata;
   logic [15:0] m_rdata, rom_addr, rom_rdata, ram_addr, ram_wdata, ram_rdata;
   logic        ram_we;
   logic [12:0] rgb;
   logic        mem_clr;
   logic [15:0] ram_mem [256];
   logic [255:0] ram_wr;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mem_bus_fabric dut (
      .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
      .m_err(m_err), .m_rdata(m_rdata), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .rgb(rgb)
   );

   // Synchronous ROM/RAM models; unwritten RAM words read as {C0, low address byte}.
   always @(posedge clk) begin
      rom_rdata <= (rom_addr == 16'h0010) ? 16'hBEEF : (rom_addr ^ 16'hA5A5);
      ram_rdata <= ram_wr[ram_addr[7:0]] ? ram_mem[ram_addr[7:0]] : {8'hC0, ram_addr[7:0]};
      if (mem_clr) ram_wr <= '0;
      else if (ram_we) begin
         ram_mem[ram_addr[7:0]] <= ram_wdata;
         ram_wr[ram_addr[7:0]]  <= 1'b1;
      end
   end

   typedef struct {
      logic [1:0]  req, we;
      logic [15:0] a0, a1, d0, d1;
      logic [1:0]  gnt;
      logic        rwe;
      logic [1:0]  rv, err;
      logic [15:0] rdata;
      logic [12:0] rgb;
   } vec_t;

   vec_t vt [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1);
      m_req   = req;
      m_we    = we;
      m_lock  = lock;
      m_addr  = {a1, a0};
      m_wdata = {d1, d0};
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           req    we     a0        a1        d0        d1        gnt    rwe   rv     err    rdata     rgb
      vt[0]  = '{2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 2'b00, 2'b00, 16'h0000, 13'h0};
      vt[1]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b01, 2'b00, 16'hBEEF, 13'h0};
      vt[2]  = '{2'b11, 2'b11, 16'h8002, 16'h8004, 16'h1111, 16'h2222, 2'b10, 1'b1, 2'b00, 2'b00, 16'h0000, 13'h0};
      vt[3]  = '{2'b11, 2'b11, 16'h8002, 16'h8006, 16'h1111, 16'h3333, 2'b01, 1'b1, 2'b10, 2'b00, 16'h0000, 13'h0};
      vt[4]  = '{2'b11, 2'b11, 16'h8008, 16'h8006, 16'h4444, 16'h3333, 2'b10, 1'b1, 2'b01, 2'b00, 16'h0000, 13'h0};
      vt[5]  = '{2'b01, 2'b01, 16'h8008, 16'h0000, 16'h4444, 16'h0000, 2'b01, 1'b1, 2'b10, 2'b00, 16'h0000, 13'h0};
      vt[6]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b01, 2'b00, 16'h0000, 13'h0};
      vt[7]  = '{2'b01, 2'b00, 16'h8002, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 2'b00, 2'b00, 16'h0000, 13'h0};
      vt[8]  = '{2'b10, 2'b00, 16'h0000, 16'h8006, 16'h0000, 16'h0000, 2'b10, 1'b0, 2'b01, 2'b00, 16'h1111, 13'h0};
      vt[9]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b10, 2'b00, 16'h3333, 13'h0};
      vt[10] = '{2'b10, 2'b10, 16'h0000, 16'hFFFF, 16'h0000, 16'h1ABC, 2'b10, 1'b0, 2'b00, 2'b00, 16'h0000, 13'h0};
      vt[11] = '{2'b01, 2'b00, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 2'b10, 2'b00, 16'h0000, 13'h1ABC};
      vt[12] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b01, 2'b00, 16'h1ABC, 13'h1ABC};
      vt[13] = '{2'b01, 2'b01, 16'h0100, 16'h0000, 16'h5555, 16'h0000, 2'b01, 1'b0, 2'b00, 2'b00, 16'h0000, 13'h1ABC};
      vt[14] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b01, 2'b01, 16'h0000, 13'h1ABC};
      vt[15] = '{2'b10, 2'b00, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 2'b10, 1'b0, 2'b00, 2'b00, 16'h0000, 13'h1ABC};
      vt[16] = '{2'b01, 2'b00, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 2'b10, 2'b00, 16'hDA5A, 13'h1ABC};
      vt[17] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b01, 2'b00, 16'hC000, 13'h1ABC};

      reset   = 1'b1;
      mem_clr = 1'b1;
      drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (2) next_cycle();
      @(negedge clk);
      chk("rst.gnt", 32'(m_gnt), 32'h0);
      chk("rst.rvalid", 32'(m_rvalid), 32'h0);
      chk("rst.err", 32'(m_err), 32'h0);
      chk("rst.rdata", 32'(m_rdata), 32'h0);
      chk("rst.rgb", 32'(rgb), 32'h0);
      chk("rst.ram_we", 32'(ram_we), 32'h0);
      next_cycle();
      reset   = 1'b0;
      mem_clr = 1'b0;

      for (int i = 0; i < 18; i++) begin
         drive(vt[i].req, vt[i].we, 2'b00, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);
         @(negedge clk);
         chk($sformatf("v%0d.gnt", i), 32'(m_gnt), 32'(vt[i].gnt));
         chk($sformatf("v%0d.ram_we", i), 32'(ram_we), 32'(vt[i].rwe));
         chk($sformatf("v%0d.rvalid", i), 32'(m_rvalid), 32'(vt[i].rv));
         chk($sformatf("v%0d.err", i), 32'(m_err), 32'(vt[i].err));
         chk($sformatf("v%0d.rdata", i), 32'(m_rdata), 32'(vt[i].rdata));
         chk($sformatf("v%0d.rgb", i), 32'(rgb), 32'(vt[i].rgb));
         next_cycle();
      end

      chk("ram.8004", 32'(ram_mem[8'h04]), 32'h2222);
      chk("ram.8008", 32'(ram_mem[8'h08]), 32'h4444);
      chk("ram.rom_wr_blocked", 32'(ram_wr[8'h00]), 32'h0);
      chk("ram.rgb_not_ram", 32'(ram_wr[8'hFF]), 32'h0);

      // Reset the cycle after a RAM read issue: completion dropped, pointer and rgb cleared.
      drive(2'b01, 2'b00, 2'b00, 16'h8006, 16'h0000, 16'h0000, 16'h0000);
      @(negedge clk);
      chk("rs.issue_gnt", 32'(m_gnt), 32'h1);
      next_cycle();
      reset = 1'b1;
      drive(2'b10, 2'b10, 2'b00, 16'h0000, 16'h8010, 16'h0000, 16'h7777);
      @(negedge clk);
      chk("rs.gnt_in_reset", 32'(m_gnt), 32'h2);
      chk("rs.ram_we", 32'(ram_we), 32'h0);
      chk("rs.rvalid", 32'(m_rvalid), 32'h0);
      chk("rs.rdata", 32'(m_rdata), 32'h0);
      next_cycle();
      reset = 1'b0;
      drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h7FFF, 16'h0000, 16'h0000);
      @(negedge clk);
      chk("rs.gnt_after", 32'(m_gnt), 32'h1);
      chk("rs.rgb", 32'(rgb), 32'h0);
      chk("rs.rvalid_after", 32'(m_rvalid), 32'h0);
      next_cycle();
      drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      @(negedge clk);
      chk("rs.rvalid_next", 32'(m_rvalid), 32'h1);
      chk("rs.rdata_next", 32'(m_rdata), 32'hBEEF);
      chk("rs.no_write", 32'(ram_wr[8'h10]), 32'h0);
      next_cycle();

      // Master0 holds lock while master1 keeps requesting, then master0 lets go.
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      begin
         logic [1:0] lk_req [4];
         logic [1:0] lk_gnt [4];
         lk_req = '{2'b11, 2'b11, 2'b11, 2'b10};
`ifdef BUS_LOCK_EN
         lk_gnt = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
         lk_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
         for (int c = 0; c < 4; c++) begin
            drive(lk_req[c], 2'b00, {1'b0, lk_req[c][0]}, 16'h0010, 16'h0020, 16'h0, 16'h0);
            @(negedge clk);
            chk($sformatf("lock.c%0d.gnt", c), 32'(m_gnt), 32'(lk_gnt[c]));
            next_cycle();
         end
      end
      drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
